// File: rtl/sccb_reg_access.sv
// OV7670 SCCB register read/write sequencer driving an AXI-stream style I2C master.
// Reads split into a write-address transaction, a STOP, then a separate read transaction.
module sccb_reg_access #(
    parameter logic [6:0]  DEV_ADDR       = 7'h21,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_error,
    output logic [6:0] s_axis_cmd_address,
    output logic       s_axis_cmd_start,
    output logic       s_axis_cmd_read,
    output logic       s_axis_cmd_write,
    output logic       s_axis_cmd_write_multiple,
    output logic       s_axis_cmd_stop,
    output logic       s_axis_cmd_valid,
    input  logic       s_axis_cmd_ready,
    output logic [7:0] s_axis_data_tdata,
    output logic       s_axis_data_tvalid,
    output logic       s_axis_data_tlast,
    input  logic       s_axis_data_tready,
    input  logic [7:0] m_axis_data_tdata,
    input  logic       m_axis_data_tvalid,
    input  logic       m_axis_data_tlast,
    output logic       m_axis_data_tready,
    input  logic       busy,
    input  logic       missed_ack,
    output logic [3:0] dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a source holds valid and its payload unchanged until that edge.
    typedef enum logic [3:0] {
        IDLE, W_CMD, W_REG, W_VAL, R_CMD, R_REG, R_WAIT, RD_CMD, RD_DATA, WAIT_IDLE, RESP
    } state_t;

    state_t      state, nxt;
    logic [7:0]  addr_q, wdata_q;
    logic [31:0] tmo_cnt;
    logic        active, timeout;
    logic        unused_tlast;

    assign unused_tlast       = m_axis_data_tlast;
    assign s_axis_cmd_address = DEV_ADDR;
    assign dbg_state          = state;
    assign active             = (state != IDLE) && (state != RESP);
    assign timeout            = active && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (req_valid)          nxt = req_write ? W_CMD : R_CMD;
            W_CMD:     if (s_axis_cmd_ready)   nxt = W_REG;
            W_REG:     if (s_axis_data_tready) nxt = W_VAL;
            W_VAL:     if (s_axis_data_tready) nxt = WAIT_IDLE;
            R_CMD:     if (s_axis_cmd_ready)   nxt = R_REG;
            R_REG:     if (s_axis_data_tready) nxt = R_WAIT;
            R_WAIT:    if (!busy)              nxt = RD_CMD;
            RD_CMD:    if (s_axis_cmd_ready)   nxt = RD_DATA;
            RD_DATA:   if (m_axis_data_tvalid) nxt = WAIT_IDLE;
            WAIT_IDLE: if (!busy)              nxt = RESP;
            RESP:      if (rsp_ready)          nxt = IDLE;
            default:                           nxt = IDLE;
        endcase
        // An expired request abandons whatever stream activity is in flight.
        if (timeout) nxt = RESP;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state                     <= IDLE;
            addr_q                    <= 8'h00;
            wdata_q                   <= 8'h00;
            tmo_cnt                   <= 32'd0;
            rsp_rdata                 <= 8'h00;
            rsp_error                 <= 2'b00;
            req_ready                 <= 1'b1;
            rsp_valid                 <= 1'b0;
            s_axis_cmd_valid          <= 1'b0;
            s_axis_cmd_start          <= 1'b0;
            s_axis_cmd_read           <= 1'b0;
            s_axis_cmd_write          <= 1'b0;
            s_axis_cmd_write_multiple <= 1'b0;
            s_axis_cmd_stop           <= 1'b0;
            s_axis_data_tdata         <= 8'h00;
            s_axis_data_tvalid        <= 1'b0;
            s_axis_data_tlast         <= 1'b0;
            m_axis_data_tready        <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && req_valid) begin
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                tmo_cnt   <= 32'd0;
                rsp_error <= 2'b00;
                rsp_rdata <= 8'h00;
            end else if (active) begin
                tmo_cnt <= tmo_cnt + 32'd1;
                if (missed_ack) rsp_error[0] <= 1'b1;
                if (timeout) begin
                    rsp_error[1] <= 1'b1;
                    rsp_rdata    <= 8'h00;
                end else if (state == RD_DATA && m_axis_data_tvalid) begin
                    rsp_rdata <= m_axis_data_tdata;
                end
            end

            // Outputs are registered from the next state so they line up with it.
            req_ready                 <= (nxt == IDLE);
            rsp_valid                 <= (nxt == RESP);
            s_axis_cmd_valid          <= (nxt == W_CMD) || (nxt == R_CMD) || (nxt == RD_CMD);
            s_axis_cmd_start          <= (nxt == W_CMD) || (nxt == R_CMD) || (nxt == RD_CMD);
            s_axis_cmd_stop           <= (nxt == W_CMD) || (nxt == R_CMD) || (nxt == RD_CMD);
            s_axis_cmd_write_multiple <= (nxt == W_CMD);
            s_axis_cmd_write          <= (nxt == R_CMD);
            s_axis_cmd_read           <= (nxt == RD_CMD);
            s_axis_data_tvalid        <= (nxt == W_REG) || (nxt == W_VAL) || (nxt == R_REG);
            s_axis_data_tlast         <= (nxt == W_VAL) || (nxt == R_REG);
            s_axis_data_tdata         <= (nxt == W_VAL) ? wdata_q :
                                         ((nxt == W_REG) || (nxt == R_REG)) ? addr_q : 8'h00;
            m_axis_data_tready        <= (nxt == RD_DATA);
        end
    end
endmodule

// File: doc/sccb_reg_access.md
SCCB_REG_ACCESS -- requirements
Module: sccb_reg_access

Interface
REQ-001 Parameter DEV_ADDR, 7'h21, 7-bit OV7670 SCCB device address (0x42 write / 0x43 read on the wire).
REQ-002 Parameter TIMEOUT_CYCLES, 2_000_000, clk cycles allowed per request before abort.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 reset_  in  1  synchronous, active-low reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  register-access request handshake.
REQ-006 req_write  in  1  1 = register write, 0 = register read.
REQ-007 req_addr, req_wdata  in  8 each  register address; write value (ignored for reads).
REQ-008 rsp_valid / rsp_ready  out / in  1 / 1  completion handshake.
REQ-009 rsp_rdata  out  8  read value (0x00 for writes).
REQ-010 rsp_error  out  2  bit0 = missed ACK seen, bit1 = timeout.
REQ-011 s_axis_cmd_address[6:0], _start, _read, _write, _write_multiple, _stop, _valid  out; s_axis_cmd_ready  in  I2C-master command stream.
REQ-012 s_axis_data_tdata[7:0], _tvalid, _tlast  out; s_axis_data_tready  in  I2C-master write-data stream.
REQ-013 m_axis_data_tdata[7:0], _tvalid, _tlast  in; m_axis_data_tready  out  I2C-master read-data stream.
REQ-014 busy, missed_ack  in  1 each  I2C-master status.

Function
REQ-015 FSM states: IDLE, W_CMD, W_REG, W_VAL, R_CMD, R_REG, R_WAIT, RD_CMD, RD_DATA, WAIT_IDLE, RESP.
REQ-016 req_ready = 1 only in IDLE; handshake latches req_write/addr/wdata, clears error flags and timeout counter, enters W_CMD (write) or R_CMD (read).
REQ-017 s_axis_cmd_address always = DEV_ADDR; each *_CMD state holds cmd_valid=1 with fixed fields until cmd_ready=1, then advances next cycle.
REQ-018 W_CMD: start=1, write_multiple=1, stop=1, others 0 -> W_REG.
REQ-019 W_REG: tdata=addr, tvalid=1, tlast=0 until tready -> W_VAL; W_VAL: tdata=wdata, tvalid=1, tlast=1 until tready -> WAIT_IDLE.
REQ-020 R_CMD: start=1, write=1, stop=1 -> R_REG; R_REG: tdata=addr, tlast=1 until tready -> R_WAIT.
REQ-021 R_WAIT: remain until busy=0 (SCCB requires STOP between address phase and read phase) -> RD_CMD.
REQ-022 RD_CMD: start=1, read=1, stop=1 -> RD_DATA; RD_DATA: m_axis_data_tready=1; on tvalid capture tdata into rsp_rdata -> WAIT_IDLE (m_axis_data_tlast ignored).
REQ-023 WAIT_IDLE: remain until busy=0 -> RESP.
REQ-024 RESP: rsp_valid=1, rsp_rdata/rsp_error stable until rsp_ready=1 -> IDLE next cycle; earliest new req accept is the cycle after.
REQ-025 Any cycle outside IDLE/RESP with missed_ack=1 sets sticky error bit0; transaction continues to completion.
REQ-026 Timeout counter increments each cycle outside IDLE/RESP; on reaching TIMEOUT_CYCLES-1, set bit1 and enter RESP next cycle, dropping all valid/tready outputs.
REQ-027 Write responses: rsp_rdata=0x00; aborted read: rsp_rdata=0x00.
REQ-028 All unused cmd flags are 0; tvalid/tready/cmd_valid are 0 in every state not naming them.

Reset
REQ-029 reset_=0 at a clock edge forces IDLE within that cycle: req_ready=1 afterwards, all valids/tready/flags 0, rsp_rdata 0x00, rsp_error 0, counter 0.
REQ-030 Reset mid-transaction abandons it with no response; stream valids drop on the following edge.

Verification
REQ-031 Write addr 0x12 val 0x80, ideal master -> cmd (start,write_multiple,stop) then data 0x12 (tlast 0), 0x80 (tlast 1); after busy falls rsp_valid, rsp_error=00.
REQ-032 Read addr 0x0A, master returns 0x76 -> write cmd + byte 0x0A tlast 1, wait busy=0, read cmd, rsp_rdata=0x76, rsp_error=00.
REQ-033 cmd_ready held low 5 cycles, tready toggling -> all fields stable while valid high, no byte duplicated or skipped.
REQ-034 missed_ack pulse during write -> rsp_error=01, response still issued once.
REQ-035 TIMEOUT_CYCLES=100, busy stuck high -> RESP at cycle 100 after accept, rsp_error=10, rsp_rdata=0x00.
REQ-036 reset_ low during RD_DATA, rsp_ready low during RESP for 10 cycles -> IDLE with reset values; response held unchanged, req_ready=0 until released.
